test_sequencer: RTL and testbench
=================================

# test_sequencer

Synthesizable self-checking harness controller for the CPU test benches. It preloads an expected sequence of register-file writes, holds the CPU in reset for a programmable number of cycles, then releases it and checks every write-back against the sequence in order. It ends in PASS, or in FAIL on a mismatch or timeout, so benches no longer depend on a fixed `#200 $finish` and waveform inspection. It sits between the testbench and the `top` instance and drives the CPU reset.

## Interface
- DATA_W, 32, register data width
- ADDR_W, 5, register address width
- DEPTH, 64, max expected-write entries (power of two)
- RST_CYCLES, 10, cycles `cpu_rst` stays high in HOLD (≥1)
- TIMEOUT, 1024, max RUN cycles before FAIL (≥1)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- load_valid  in  1  expected-entry valid
- load_ready  out  1  entry accepted when valid&ready
- load_addr  in  ADDR_W  expected destination register
- load_data  in  DATA_W  expected write value
- start  in  1  begin test (pulse, IDLE only)
- clear  in  1  return to IDLE from PASS/FAIL, empty sequence
- cpu_rst  out  1  active-high reset to CPU
- wb_we / wb_waddr / wb_wdata  in  1/ADDR_W/DATA_W  CPU regfile write port
- done  out  1  in PASS or FAIL
- pass  out  1  in PASS
- err_code  out  2  0 none, 1 mismatch, 2 timeout
- err_index  out  log2(DEPTH)+1  sequence index at failure
- err_wdata  out  DATA_W  offending write value (0 on timeout)
- cycles  out  32  RUN cycle count, frozen on done

## Operation
- States: IDLE, HOLD, RUN, PASS, FAIL.
- IDLE: load_ready = (count < DEPTH). Each accepted entry is stored at index count, then count++.
- IDLE → HOLD on start. Start in any other state is ignored.
- HOLD: counts RST_CYCLES cycles, then → RUN. The ptr and cycles registers clear on HOLD entry.
- RUN: writes with wb_we=1 and wb_waddr≠0 are checked. Writes to r0 are ignored.
  - On a match of (addr, data) with entry[ptr], ptr++.
  - On a mismatch, → FAIL with err_code=1, err_index=ptr, err_wdata=wb_wdata.
- RUN → PASS when ptr reaches count.
  - With count=0, RUN → PASS on its first cycle, unless that cycle carries a write, which is a mismatch with err_index=0.
- RUN timeout: cycles reaching TIMEOUT-1 with ptr<count and no completing match that cycle → FAIL with err_code=2.
- A completing match in the same cycle as a timeout wins, giving PASS.
- PASS/FAIL are sticky and ignore all wb_* traffic. clear → IDLE with count=0 and error fields zeroed.
- clear outside PASS/FAIL is ignored.

## Timing
- Reset values: state IDLE, cpu_rst=1, load_ready=1, done=0, pass=0, err_code=0, err_index=0, err_wdata=0, cycles=0. count=0 and ptr=0.
- Reset mid-operation forces all of the above immediately (asynchronous). The expected memory contents are don't-care.
- cpu_rst=1 in IDLE and HOLD, and 0 from the first RUN cycle onward, including PASS/FAIL. It is a registered output.
- HOLD lasts exactly RST_CYCLES clock cycles.
- Check latency is 1 cycle: a write sampled at edge k updates ptr, state and the err_* outputs at edge k, visible after k.
- A load on the same cycle as start is accepted and included in count.
- cycles increments once per RUN cycle and saturates at 2^32-1.

## Structure
- The shared header (defines) holds the state encodings, the err_code constants (ERR_NONE, ERR_MISMATCH, ERR_TIMEOUT), and the `clog2` macro/function.
- One sub-module, `exp_mem`: DEPTH×(ADDR_W+DATA_W) memory with a synchronous write port and an asynchronous read port. It is indexed by count on write and by ptr on read.
- The FSM, counters and comparator live in `test_sequencer`.

## Test plan
- Reset deassert, load 3 entries {r1=0x1, r3=0x2, r31=0x8}, start → cpu_rst high for exactly 10 cycles. Writes r1=1, r0=5, r3=2, r31=8 → pass=1 the cycle after the r31 write; r0 is ignored.
- Same load, second write r3=0x3 → FAIL, err_code=1, err_index=1, err_wdata=0x3. Further writes leave the outputs unchanged.
- TIMEOUT=16, 2 entries, only the first write occurs → FAIL exactly 16 RUN cycles in, err_code=2, err_index=1, cycles=16.
- Load 64 entries → load_ready drops after the 64th. A 65th load_valid is not accepted and count stays 64.
- Final matching write on the timeout cycle → PASS, err_code=0.
- rst low mid-RUN → cpu_rst=1, state IDLE and all outputs at reset values immediately. clear after FAIL → IDLE with load_ready=1.

Source files
------------

// File: rtl/test_sequencer_pkg.sv
// test_sequencer_pkg: shared state encodings, error codes and width helper
// for the CPU test sequencer.
package test_sequencer_pkg;

    typedef enum logic [2:0] {S_IDLE, S_HOLD, S_RUN, S_PASS, S_FAIL} state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISMATCH = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;

    function automatic int f_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/test_sequencer_exp_mem.sv
// exp_mem: expected-write storage, synchronous write by load count and
// asynchronous read by the check pointer.
module exp_mem
    import test_sequencer_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int W     = 37,
    localparam int AW   = f_clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);

    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk)
        if (i_we) r_mem[i_waddr] <= i_wdata;

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/test_sequencer.sv
// test_sequencer: holds the CPU in reset, then checks its register-file
// write-backs in order against a preloaded sequence, ending in PASS or FAIL.
module test_sequencer
    import test_sequencer_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int DEPTH      = 64,
    parameter int RST_CYCLES = 10,
    parameter int TIMEOUT    = 1024,
    localparam int AW        = f_clog2(DEPTH),
    localparam int IW        = AW + 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load_valid,
    output logic              o_load_ready,
    input  logic [ADDR_W-1:0] i_load_addr,
    input  logic [DATA_W-1:0] i_load_data,
    input  logic              i_start,
    input  logic              i_clear,
    output logic              o_cpu_rst,
    input  logic              i_wb_we,
    input  logic [ADDR_W-1:0] i_wb_waddr,
    input  logic [DATA_W-1:0] i_wb_wdata,
    output logic              o_done,
    output logic              o_pass,
    output logic [1:0]        o_err_code,
    output logic [IW-1:0]     o_err_index,
    output logic [DATA_W-1:0] o_err_wdata,
    output logic [31:0]       o_cycles
);

    state_t                   r_state, w_state_nxt;
    logic [IW-1:0]            r_count, r_ptr, r_err_index;
    logic [31:0]              r_hold, r_cycles;
    logic [1:0]               r_err_code;
    logic [DATA_W-1:0]        r_err_wdata;
    logic                     r_cpu_rst;
    logic [ADDR_W+DATA_W-1:0] w_exp;
    logic                     w_load, w_check, w_match, w_complete, w_hit, w_mm, w_to;

    assign o_load_ready = (r_state == S_IDLE) && (r_count < IW'(DEPTH));
    assign w_load       = i_load_valid && o_load_ready;
    assign w_check      = i_wb_we && (i_wb_waddr != '0);
    assign w_match      = w_check && (r_ptr < r_count) && (w_exp == {i_wb_waddr, i_wb_wdata});
    // A completing cycle either consumes the last entry or, with nothing
    // left to expect, carries no checked write at all.
    assign w_complete   = w_match ? (r_ptr + IW'(1) == r_count) : (!w_check && r_ptr == r_count);
    assign w_hit        = (r_state == S_RUN) && w_match;

    exp_mem #(.DEPTH(DEPTH), .W(ADDR_W + DATA_W)) u_exp_mem (
        .i_clk   (i_clk),
        .i_we    (w_load),
        .i_waddr (r_count[AW-1:0]),
        .i_wdata ({i_load_addr, i_load_data}),
        .i_raddr (r_ptr[AW-1:0]),
        .o_rdata (w_exp)
    );

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_mm        = 1'b0;
        w_to        = 1'b0;
        case (r_state)
            S_IDLE: w_state_nxt = i_start ? S_HOLD : S_IDLE;
            S_HOLD: w_state_nxt = (r_hold == 32'(RST_CYCLES - 1)) ? S_RUN : S_HOLD;
            S_RUN: begin
                if (w_check && !w_match) begin
                    w_mm        = 1'b1;
                    w_state_nxt = S_FAIL;
                end else if (w_complete) begin
                    w_state_nxt = S_PASS;
                end else if (r_cycles == 32'(TIMEOUT - 1)) begin
                    w_to        = 1'b1;
                    w_state_nxt = S_FAIL;
                end
            end
            S_PASS, S_FAIL: w_state_nxt = i_clear ? S_IDLE : r_state;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cpu_rst   <= 1'b1;
            r_count     <= '0;
            r_ptr       <= '0;
            r_hold      <= '0;
            r_cycles    <= '0;
            r_err_code  <= ERR_NONE;
            r_err_index <= '0;
            r_err_wdata <= '0;
        end else begin
            r_cpu_rst <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_HOLD);
            if (w_load) r_count <= r_count + IW'(1);
            if (r_state == S_IDLE && i_start) begin
                r_ptr    <= '0;
                r_cycles <= '0;
                r_hold   <= '0;
            end
            if (r_state == S_HOLD) r_hold <= r_hold + 32'd1;
            if (r_state == S_RUN && r_cycles != '1) r_cycles <= r_cycles + 32'd1;
            if (w_hit) r_ptr <= r_ptr + IW'(1);
            if (w_mm) begin
                r_err_code  <= ERR_MISMATCH;
                r_err_index <= r_ptr;
                r_err_wdata <= i_wb_wdata;
            end
            if (w_to) begin
                r_err_code  <= ERR_TIMEOUT;
                r_err_index <= r_ptr + IW'(w_hit);
                r_err_wdata <= '0;
            end
            if ((r_state == S_PASS || r_state == S_FAIL) && i_clear) begin
                r_count     <= '0;
                r_err_code  <= ERR_NONE;
                r_err_index <= '0;
                r_err_wdata <= '0;
            end
        end
    end

    assign o_cpu_rst   = r_cpu_rst;
    assign o_done      = (r_state == S_PASS) || (r_state == S_FAIL);
    assign o_pass      = (r_state == S_PASS);
    assign o_err_code  = r_err_code;
    assign o_err_index = r_err_index;
    assign o_err_wdata = r_err_wdata;
    assign o_cycles    = r_cycles;

endmodule

// File: tb/tb_test_sequencer.sv
// tb_test_sequencer: scoreboard bench; expected writes are queued as they are
// loaded and retired by a reference model as the CPU write stream is driven.
module tb_test_sequencer;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic        i_load_valid, i_start, i_clear, i_wb_we;
    logic [4:0]  i_load_addr, i_wb_waddr;
    logic [31:0] i_load_data, i_wb_wdata;
    logic        o_load_ready, o_cpu_rst, o_done, o_pass;
    logic [1:0]  o_err_code;
    logic [6:0]  o_err_index;
    logic [31:0] o_err_wdata, o_cycles;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [36:0] exp_q[$];
    bit          m_done, m_pass;
    logic [1:0]  m_err;
    int          m_idx, m_eidx, m_cyc;
    logic [31:0] m_wdata;

    test_sequencer #(
        .DATA_W(32), .ADDR_W(5), .DEPTH(64), .RST_CYCLES(10), .TIMEOUT(TO)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (i_rst_n),
        .i_load_valid (i_load_valid),
        .o_load_ready (o_load_ready),
        .i_load_addr  (i_load_addr),
        .i_load_data  (i_load_data),
        .i_start      (i_start),
        .i_clear      (i_clear),
        .o_cpu_rst    (o_cpu_rst),
        .i_wb_we      (i_wb_we),
        .i_wb_waddr   (i_wb_waddr),
        .i_wb_wdata   (i_wb_wdata),
        .o_done       (o_done),
        .o_pass       (o_pass),
        .o_err_code   (o_err_code),
        .o_err_index  (o_err_index),
        .o_err_wdata  (o_err_wdata),
        .o_cycles     (o_cycles)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_done = 0; m_pass = 0; m_err = 2'd0; m_idx = 0; m_eidx = 0; m_wdata = '0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cpu_rst"}, o_cpu_rst, 1);
        chk({tag, "_ready"}, o_load_ready, 1);
        chk({tag, "_done"}, o_done, 0);
        chk({tag, "_pass"}, o_pass, 0);
        chk({tag, "_err_code"}, o_err_code, 0);
        chk({tag, "_err_index"}, o_err_index, 0);
        chk({tag, "_err_wdata"}, o_err_wdata, 0);
        chk({tag, "_cycles"}, o_cycles, 0);
    endtask

    task automatic load(input logic [4:0] a, input logic [31:0] d);
        chk("load_ready", o_load_ready, 1);
        i_load_valid = 1; i_load_addr = a; i_load_data = d;
        tick();
        i_load_valid = 0;
        exp_q.push_back({a, d});
    endtask

    task automatic start_hold();
        int n;
        i_start = 1;
        tick();
        i_start = 0;
        m_done = 0; m_pass = 0; m_idx = 0; m_cyc = 0;
        n = 0;
        while (o_cpu_rst && n < 50) begin
            tick();
            n++;
        end
        chk("hold_len", n, 10);
    endtask

    task automatic do_clear();
        i_clear = 1;
        tick();
        i_clear = 0;
        model_clear();
        chk("clr_done", o_done, 0);
        chk("clr_ready", o_load_ready, 1);
        chk("clr_err_code", o_err_code, 0);
        chk("clr_err_index", o_err_index, 0);
    endtask

    // One RUN cycle: drive the write, let the model predict, compare outputs.
    task automatic run_cycle(input logic we, input logic [4:0] a, input logic [31:0] d);
        i_wb_we = we; i_wb_waddr = a; i_wb_wdata = d;
        tick();
        i_wb_we = 0;
        if (!m_done) begin
            m_cyc++;
            if (we && a != 0) begin
                if (exp_q.size() > 0 && exp_q[0] == {a, d}) begin
                    void'(exp_q.pop_front());
                    m_idx++;
                    if (exp_q.size() == 0) begin m_done = 1; m_pass = 1; end
                end else begin
                    m_done = 1; m_err = 2'd1; m_eidx = m_idx; m_wdata = d;
                end
            end else if (exp_q.size() == 0) begin
                m_done = 1; m_pass = 1;
            end
            if (!m_done && m_cyc == TO) begin
                m_done = 1; m_err = 2'd2; m_eidx = m_idx; m_wdata = '0;
            end
        end
        chk("done", o_done, m_done);
        chk("pass", o_pass, m_pass);
        chk("err_code", o_err_code, m_err);
        chk("err_index", o_err_index, m_eidx);
        chk("err_wdata", o_err_wdata, m_wdata);
        chk("cycles", o_cycles, m_cyc);
        chk("run_cpu_rst", o_cpu_rst, 0);
    endtask

    initial begin
        int n;
        i_rst_n = 0; i_load_valid = 0; i_start = 0; i_clear = 0; i_wb_we = 0;
        i_load_addr = '0; i_load_data = '0; i_wb_waddr = '0; i_wb_wdata = '0;
        model_clear();
        m_cyc = 0;
        tick(); tick();
        chk_reset_vals("rst");
        i_rst_n = 1;
        tick();
        chk_reset_vals("post_rst");

        // In-order match with an ignored r0 write
        load(5'd1, 32'h1); load(5'd3, 32'h2); load(5'd31, 32'h8);
        start_hold();
        run_cycle(1, 5'd1, 32'h1);
        run_cycle(1, 5'd0, 32'h5);
        run_cycle(1, 5'd3, 32'h2);
        run_cycle(1, 5'd31, 32'h8);
        chk("t1_pass", o_pass, 1);
        do_clear();

        // Mismatch on the second entry, then sticky FAIL
        load(5'd1, 32'h1); load(5'd3, 32'h2); load(5'd31, 32'h8);
        start_hold();
        run_cycle(1, 5'd1, 32'h1);
        run_cycle(1, 5'd3, 32'h3);
        chk("t2_err_index", o_err_index, 1);
        chk("t2_err_wdata", o_err_wdata, 32'h3);
        run_cycle(1, 5'd31, 32'h8);
        run_cycle(0, 5'd0, 32'h0);
        do_clear();

        // Timeout after the first of two entries
        load(5'd2, 32'hA); load(5'd4, 32'hB);
        start_hold();
        run_cycle(1, 5'd2, 32'hA);
        n = 1;
        while (!o_done && n < 40) begin
            run_cycle(0, 5'd0, 32'h0);
            n++;
        end
        chk("t3_to_len", n, TO);
        chk("t3_err_code", o_err_code, 2);
        chk("t3_cycles", o_cycles, TO);
        do_clear();

        // Final match on the timeout cycle wins
        load(5'd5, 32'h55);
        start_hold();
        repeat (TO - 1) run_cycle(0, 5'd0, 32'h0);
        run_cycle(1, 5'd5, 32'h55);
        chk("t5_pass", o_pass, 1);
        chk("t5_err_code", o_err_code, 0);
        do_clear();

        // Empty sequence: pass on first RUN cycle, or mismatch at index 0
        start_hold();
        run_cycle(0, 5'd0, 32'h0);
        chk("t6_pass", o_pass, 1);
        do_clear();
        start_hold();
        run_cycle(1, 5'd3, 32'h9);
        chk("t6_err_code", o_err_code, 1);
        do_clear();

        // Full memory, rejected 65th load, then asynchronous reset mid-RUN
        for (int i = 0; i < 64; i++) load(5'((i % 31) + 1), 32'(i * 3 + 100));
        chk("full_ready", o_load_ready, 0);
        i_load_valid = 1; i_load_addr = 5'd1; i_load_data = 32'hDEAD;
        tick();
        i_load_valid = 0;
        chk("ovf_ready", o_load_ready, 0);
        start_hold();
        run_cycle(1, 5'd1, 32'd100);
        i_rst_n = 0;
        #1;
        chk_reset_vals("async_rst");
        tick();
        i_rst_n = 1;
        model_clear();
        m_cyc = 0;
        tick();
        chk_reset_vals("rst_release");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
